gray_conv_arbiter: RTL

- Shares one binary↔Gray conversion engine among NREQ requesters using round-robin arbitration.
- Binary→Gray completes in one cycle. Gray→binary is computed serially, one bit per cycle, so a single XOR stage serves all requesters.
- Only one conversion is in flight at a time. The result is held on a valid/ready response port until consumed.
- Sits between the test/control masters and the shared code-conversion datapath.

---
 rtl/gray_conv_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gray_conv_arbiter.sv
// ============================================================================
// gray_conv_arbiter : round-robin shared binary<->Gray converter, serial G2B.
// Optional GRAY_ARB_STATS_EN adds a saturating completed-conversion counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gray_conv_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_mode,
    output logic [15:0]           conv_count
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B2G  = 2'd1,
        G2B  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_valid_q;
    logic             rsp_mode_q;
    logic [CW-1:0]    bit_q;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_gnt_mode;
    logic             w_found;
    logic [IDW:0]     w_sum;
    logic             w_rsp_fire;

    // Scan from the requester after the last winner, wrapping once.
    always_comb begin
        w_grant    = '0;
        w_gnt_idx  = '0;
        w_gnt_data = '0;
        w_gnt_mode = 1'b0;
        w_found    = 1'b0;
        w_sum      = '0;
        if (state_q == IDLE) begin
            for (int k = 1; k <= NREQ; k++) begin
                w_sum = {1'b0, last_q} + (IDW+1)'(k);
                if (w_sum >= (IDW+1)'(NREQ)) begin
                    w_sum = w_sum - (IDW+1)'(NREQ);
                end
                if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                    w_found   = 1'b1;
                    w_gnt_idx = w_sum[IDW-1:0];
                end
            end
            if (w_found) begin
                w_grant[w_gnt_idx] = 1'b1;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (w_grant[j]) begin
                    w_gnt_data = req_data[j*WIDTH +: WIDTH];
                    w_gnt_mode = req_mode[j];
                end
            end
        end
    end

    assign w_rsp_fire = (state_q == DONE) && rsp_valid_q && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ-1);
            op_q        <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_mode_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            bit_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        op_q       <= w_gnt_data;
                        rsp_id_q   <= w_gnt_idx;
                        rsp_mode_q <= w_gnt_mode;
                        last_q     <= w_gnt_idx;
                        if (w_gnt_mode) begin
                            // The Gray MSB is already the binary MSB.
                            rsp_data_q <= {w_gnt_data[WIDTH-1], {(WIDTH-1){1'b0}}};
                            bit_q      <= CW'(WIDTH-2);
                            state_q    <= G2B;
                        end else begin
                            state_q <= B2G;
                        end
                    end
                end
                B2G: begin
                    rsp_data_q  <= op_q ^ (op_q >> 1);
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                G2B: begin
                    rsp_data_q[bit_q] <= rsp_data_q[bit_q + 1'b1] ^ op_q[bit_q];
                    bit_q             <= bit_q - 1'b1;
                    if (bit_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (w_rsp_fire) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_mode  = rsp_mode_q;

`ifdef GRAY_ARB_STATS_EN
    logic [15:0] conv_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_count_q <= 16'd0;
        end else if (w_rsp_fire && (conv_count_q != 16'hFFFF)) begin
            conv_count_q <= conv_count_q + 16'd1;
        end
    end

    assign conv_count = conv_count_q;
`else
    assign conv_count = 16'd0;
`endif

endmodule

`default_nettype wire
